// File: rtl/npu_pkg.sv
// Shared types and width helpers for the NPU register-access arbitration blocks.
package npu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Word-address width (REG_ADDR_W) for a register file of num_regs entries.
    function automatic int reg_addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, with wrap.
module rr_pick
    import npu_pkg::*;
#(
    parameter int  N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW-1:0] idx_s;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant_idx = '0;
        idx_s     = '0;
        any_req   = |req;
        for (int k = N; k >= 1; k--) begin
            idx_s = IW'((int'(last_grant) + k) % N);
            if (req[idx_s]) begin
                grant_idx = idx_s;
            end else begin
                grant_idx = grant_idx;
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one configuration-register port between NUM_REQ
// requesters; one transaction at a time through IDLE -> ACCESS -> RESP.
module reg_access_arbiter
    import npu_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 64,
    localparam int AW         = reg_addr_w(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          reg_wr_en,
    output logic [AW-1:0]                 reg_wr_addr,
    output logic [DATA_WIDTH-1:0]         reg_wr_data,
    output logic                          reg_rd_en,
    output logic [AW-1:0]                 reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]         reg_rd_data
);

    localparam int            GW       = idx_w(NUM_REQ);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

    arb_state_t              state_q, state_d;
    logic [GW-1:0]           gnt_q, gnt_d;
    logic [GW-1:0]           last_q, last_d;
    logic                    we_q, we_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]      ready_s;
    logic [GW-1:0]           pick_s;
    logic                    any_req_s;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .grant_idx  (pick_s),
        .any_req    (any_req_s)
    );

    // Next-state and registered-output decode for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        ready_s     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req_s) begin
                    ready_s[pick_s] = 1'b1;
                    gnt_d           = pick_s;
                    we_d            = req_we[pick_s];
                    addr_d          = req_addr[pick_s*AW +: AW];
                    wdata_d         = req_wdata[pick_s*DATA_WIDTH +: DATA_WIDTH];
                    wr_en_d         = req_we[pick_s];
                    rd_en_d         = ~req_we[pick_s];
                    state_d         = ARB_ACCESS;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                // Read data is combinational from reg_rd_addr, so capture it now.
                rdata_d             = we_q ? '0 : reg_rd_data;
                rsp_valid_d         = '0;
                rsp_valid_d[gnt_q]  = 1'b1;
                state_d             = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    last_d      = gnt_q;
                    state_d     = ARB_IDLE;
                end else begin
                    state_d = ARB_RESP;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = ARB_IDLE;
            end
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            last_q      <= LAST_RST;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    // The grant is combinational, so it is masked while reset is asserted.
    assign req_ready   = ready_s & {NUM_REQ{rst_n}};
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;
    assign reg_wr_addr = addr_q;
    assign reg_rd_addr = addr_q;
    assign reg_wr_data = wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter with three requesters and a behavioural register file.
module tb_reg_access_arbiter;

    localparam int NREQ  = 3;
    localparam int DW    = 32;
    localparam int NREGS = 64;
    localparam int AW    = 6;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              reg_wr_en;
    logic [AW-1:0]     reg_wr_addr;
    logic [DW-1:0]     reg_wr_data;
    logic              reg_rd_en;
    logic [AW-1:0]     reg_rd_addr;
    logic [DW-1:0]     reg_rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] rf [NREGS] = '{default: 32'h5A5A_0000};
    logic [DW-1:0] shadow [NREGS];
    int            m_last;
    int            grants[$];
    bit [NREQ-1:0] pend;
    logic          p_we    [NREQ];
    logic [AW-1:0] p_addr  [NREQ];
    logic [DW-1:0] p_wdata [NREQ];

    reg_access_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_wr_en) rf[reg_wr_addr] <= reg_wr_data;
    end
    assign reg_rd_data = rf[reg_rd_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic v, input logic we,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    function automatic int rr_next(input int last, input bit [NREQ-1:0] p);
        for (int k = 1; k <= NREQ; k++) begin
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        m_last    = NREQ - 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = '1; req_we = '1; req_addr = '1; req_wdata = '1; rsp_ready = '1;
        #1 rst_n = 1'b0;
        #2;
        n_chk++;
        if ({req_ready, rsp_valid, rsp_rdata, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h we=%b wa=%h wd=%h re=%b ra=%h expected all zero",
                     req_ready, rsp_valid, rsp_rdata, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr);
        end
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        step();
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        #1;
        n_chk++;
        if ({reg_wr_en, reg_rd_en, rsp_valid} !== '0) begin
            n_fail++; $display("FAIL reset_release_idle: we=%b re=%b rv=%b expected 0", reg_wr_en, reg_rd_en, rsp_valid);
        end
        step();
    endtask

    task automatic test_write();
        drive_req(0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
        rsp_ready = '1;
        #1;
        n_chk++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL wr_grant: req_ready=%b expected 001", req_ready); end
        step();
        drive_req(0, 1'b0, 1'b0, 6'd0, 32'h0);
        n_chk++;
        if ({reg_wr_en, reg_rd_en, reg_wr_addr, reg_wr_data} !== {1'b1, 1'b0, 6'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_access: we=%b re=%b addr=%0d data=%h expected 1 0 5 deadbeef",
                               reg_wr_en, reg_rd_en, reg_wr_addr, reg_wr_data);
        end
        step();
        n_chk++;
        if ({rsp_valid, rsp_rdata, reg_wr_en} !== {3'b001, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL wr_resp: rsp_valid=%b rdata=%h wr_en=%b expected 001 0 0", rsp_valid, rsp_rdata, reg_wr_en);
        end
        step();
        n_chk++;
        if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL wr_resp_done: rsp_valid=%b expected 000", rsp_valid); end
        shadow[5] = 32'hDEADBEEF;
        m_last    = 0;
    endtask

    task automatic test_reset_mid();
        drive_req(0, 1'b1, 1'b1, 6'd11, 32'h1234_5678);
        #1;
        step();
        drive_req(0, 1'b0, 1'b0, 6'd0, 32'h0);
        n_chk++;
        if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_access: wr_en=%b expected 1", reg_wr_en); end
        drive_req(0, 1'b1, 1'b1, 6'd11, 32'hCAFE_0011);
        drive_req(1, 1'b1, 1'b0, 6'd3, 32'h0);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req_ready, rsp_valid, rsp_rdata, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr} !== '0) begin
            n_fail++; $display("FAIL rstmid_async: rdy=%b rv=%b we=%b wa=%h wd=%h expected all zero",
                               req_ready, rsp_valid, reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = NREQ - 1;
        #1;
        n_chk++;
        if ({reg_wr_en, reg_rd_en, req_ready} !== {1'b0, 1'b0, 3'b001}) begin
            n_fail++; $display("FAIL rstmid_release: wr_en=%b rd_en=%b req_ready=%b expected 0 0 001", reg_wr_en, reg_rd_en, req_ready);
        end
        step();
        drive_req(0, 1'b0, 1'b0, 6'd0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 6'd0, 32'h0);
        n_chk++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 6'd11, 32'hCAFE_0011}) begin
            n_fail++; $display("FAIL rstmid_new_write: we=%b addr=%0d data=%h expected 1 11 cafe0011", reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        step();
        step();
        shadow[11] = 32'hCAFE_0011;
        m_last     = 0;
    endtask

    task automatic test_read();
        drive_req(1, 1'b1, 1'b0, 6'd5, 32'h0);
        #1;
        n_chk++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rd_grant: req_ready=%b expected 010", req_ready); end
        step();
        drive_req(1, 1'b0, 1'b0, 6'd0, 32'h0);
        n_chk++;
        if ({reg_rd_en, reg_wr_en, reg_rd_addr} !== {1'b1, 1'b0, 6'd5}) begin
            n_fail++; $display("FAIL rd_access: re=%b we=%b addr=%0d expected 1 0 5", reg_rd_en, reg_wr_en, reg_rd_addr);
        end
        step();
        n_chk++;
        if ({rsp_valid, rsp_rdata} !== {3'b010, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rd_resp: rsp_valid=%b rdata=%h expected 010 deadbeef", rsp_valid, rsp_rdata);
        end
        step();
        m_last = 1;
    endtask

    // Transaction-level engine: requesters in mask issue random transactions, the model
    // predicts grants, strobes and responses and counts completed transactions.
    task automatic run_engine(input bit [NREQ-1:0] mask, input bit cont, input bit rand_rsp,
                              input bit max_addr, input int n_txn);
        int phase = 0, cur = 0, done = 0, cyc = 0, g;
        logic          cur_we = 1'b0;
        logic [AW-1:0] cur_addr = '0;
        logic [DW-1:0] cur_wdata = '0, exp_rd = '0;
        logic [NREQ-1:0] exp_rdy, exp_v;
        logic [1:0]      exp_str;
        grants.delete();
        pend = '0;
        while (done < n_txn && cyc < 3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && mask[i] && (cont || $urandom_range(0, 2) == 0)) begin
                    pend[i]    = 1'b1;
                    p_we[i]    = 1'($urandom_range(0, 1));
                    p_addr[i]  = max_addr ? AW'(NREGS - 1) : AW'($urandom_range(0, NREGS - 1));
                    p_wdata[i] = $urandom;
                end
                drive_req(i, pend[i], pend[i] ? p_we[i] : 1'b0, pend[i] ? p_addr[i] : '0, pend[i] ? p_wdata[i] : '0);
            end
            rsp_ready = rand_rsp ? NREQ'($urandom) : '1;
            #1;
            g = -1;
            exp_rdy = '0;
            if (phase == 0) begin
                g = rr_next(m_last, pend);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            n_chk++;
            if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL eng_grant: req_ready=%b expected %b", req_ready, exp_rdy); end
            exp_str = (phase == 1) ? (cur_we ? 2'b10 : 2'b01) : 2'b00;
            n_chk++;
            if ({reg_wr_en, reg_rd_en} !== exp_str) begin
                n_fail++; $display("FAIL eng_strobe: wr/rd=%b expected %b", {reg_wr_en, reg_rd_en}, exp_str);
            end
            if (phase != 0) begin
                n_chk++;
                if ({reg_wr_addr, reg_rd_addr, reg_wr_data} !== {cur_addr, cur_addr, cur_wdata}) begin
                    n_fail++; $display("FAIL eng_payload: wa=%0d ra=%0d wd=%h expected %0d %0d %h",
                                       reg_wr_addr, reg_rd_addr, reg_wr_data, cur_addr, cur_addr, cur_wdata);
                end
            end
            exp_v = '0;
            if (phase == 2) exp_v[cur] = 1'b1;
            n_chk++;
            if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL eng_rsp_valid: rsp_valid=%b expected %b", rsp_valid, exp_v); end
            if (phase == 2) begin
                n_chk++;
                if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL eng_rdata: rdata=%h expected %h", rsp_rdata, exp_rd); end
            end
            @(posedge clk);
            case (phase)
                0: if (g >= 0) begin
                    cur = g; cur_we = p_we[g]; cur_addr = p_addr[g]; cur_wdata = p_wdata[g];
                    pend[g] = 1'b0; grants.push_back(g); phase = 1;
                end
                1: begin
                    if (cur_we) begin shadow[cur_addr] = cur_wdata; exp_rd = '0; end
                    else exp_rd = shadow[cur_addr];
                    phase = 2;
                end
                default: if (rsp_ready[cur]) begin m_last = cur; done++; phase = 0; end
            endcase
            #1;
            cyc++;
        end
        n_chk++;
        if (done != n_txn) begin n_fail++; $display("FAIL eng_timeout: completed %0d expected %0d", done, n_txn); end
        req_valid = '0;
        rsp_ready = '1;
    endtask

    task automatic test_rotation();
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};
        do_reset();
        run_engine(3'b011, 1'b1, 1'b0, 1'b0, 6);
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (i >= grants.size() || grants[i] != exp_order[i]) begin
                n_fail++; $display("FAIL rot_order[%0d]: got %0d expected %0d", i, (i < grants.size()) ? grants[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp;
        do_reset();
        drive_req(0, 1'b1, 1'b0, 6'd7, 32'h0);
        drive_req(1, 1'b1, 1'b1, 6'd9, 32'hC0FF_EE01);
        rsp_ready = '0;
        #1;
        n_chk++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL stall_grant: req_ready=%b expected 001", req_ready); end
        step();
        drive_req(0, 1'b0, 1'b0, 6'd0, 32'h0);
        step();
        exp = shadow[7];
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if ({rsp_valid, rsp_rdata, req_ready} !== {3'b001, exp, 3'b000}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: rv=%b rdata=%h rdy=%b expected 001 %h 000", c, rsp_valid, rsp_rdata, req_ready, exp);
            end
            step();
        end
        rsp_ready = 3'b001;
        step();
        n_chk++;
        if ({req_ready, rsp_valid} !== {3'b010, 3'b000}) begin
            n_fail++; $display("FAIL stall_next_grant: rdy=%b rv=%b expected 010 000", req_ready, rsp_valid);
        end
        step();
        drive_req(1, 1'b0, 1'b0, 6'd0, 32'h0);
        n_chk++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 6'd9, 32'hC0FF_EE01}) begin
            n_fail++; $display("FAIL stall_req1_write: we=%b addr=%0d data=%h expected 1 9 c0ffee01", reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        shadow[9] = 32'hC0FF_EE01;
        rsp_ready = '1;
        step();
        step();
        m_last = 1;
    endtask

    task automatic test_max_addr();
        int exp_order[4] = '{0, 2, 0, 2};
        do_reset();
        run_engine(3'b101, 1'b1, 1'b0, 1'b1, 4);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= grants.size() || grants[i] != exp_order[i]) begin
                n_fail++; $display("FAIL max_order[%0d]: got %0d expected %0d", i, (i < grants.size()) ? grants[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_random();
        run_engine(3'b111, 1'b0, 1'b1, 1'b0, 40);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) shadow[i] = 32'h5A5A_0000;
        m_last = NREQ - 1;
        test_reset();
        test_write();
        test_reset_mid();
        test_read();
        test_rotation();
        test_stall();
        test_max_addr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
